// File: rtl/switch_pkg.sv
// switch_pkg
//   Shared constants for the switch_debounce peripheral.
//   DATA_W     : system bus data width.
//   ADR_*      : word register select codes for the four registers.
package switch_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADR_STATE  = 2'd0;  // debounced state, read-only
  localparam logic [1:0] ADR_CHANGE = 2'd1;  // sticky change flags, write-1-to-clear
  localparam logic [1:0] ADR_MASK   = 2'd2;  // interrupt mask, read/write
  localparam logic [1:0] ADR_RAW    = 2'd3;  // synchroniser output, read-only

endpackage

// File: rtl/switch_debounce_bit.sv
// debounce_bit
//   One switch channel: 2-flop synchroniser, debounce counter and the
//   accepted (stable) level. accept_o is high for the single cycle in which
//   the next clock edge will flip stable_o, so the parent can set its sticky
//   change flag on that very edge.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   sw_i     : asynchronous switch input
//   raw_o    : synchronised input (second flop)
//   stable_o : debounced level
//   accept_o : new level accepted at the next edge
module debounce_bit #(
  parameter int CNT_W    = 20,
  parameter int DEBOUNCE = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic raw_o,
  output logic stable_o,
  output logic accept_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept_s;

  // Debounce next-state: count consecutive cycles the synchronised input
  // disagrees with the stable level; any agreement restarts the window.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_s = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = CNT_ZERO;
      stable_d = s2_q;
      accept_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= CNT_ZERO;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign raw_o    = s2_q;
  assign stable_o = stable_q;
  assign accept_o = accept_s;

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
//   Bus peripheral for WIDTH debounced switch inputs with sticky change
//   flags and a masked level interrupt.
// Ports:
//   CLK_I  : clock, rising edge
//   RST_I  : synchronous active-low reset
//   dipsw  : asynchronous switch inputs
//   STB_I  : bus strobe, held until ACK_O
//   WE_I   : 1 = write, 0 = read
//   ADR_I  : register select (STATE, CHANGE, MASK, RAW)
//   DAT_I  : write data
//   DAT_O  : registered read data, valid while ACK_O
//   ACK_O  : one-cycle acknowledge, every access takes two cycles
//   INT_O  : |(CHANGE & MASK)
module switch_debounce
  import switch_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 20,
  parameter int DEBOUNCE = 1000000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [WIDTH-1:0]  dipsw,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [1:0]        ADR_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              ACK_O,
  output logic              INT_O
);

  logic [WIDTH-1:0]  raw_s;
  logic [WIDTH-1:0]  stable_s;
  logic [WIDTH-1:0]  accept_s;

  logic [WIDTH-1:0]  change_q;
  logic [WIDTH-1:0]  change_d;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  mask_d;
  logic              ack_q;
  logic              ack_d;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] dat_d;
  logic [WIDTH-1:0]  clear_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              access_s;

  // Zero-extend a channel vector onto the bus; bits >= WIDTH read 0.
  function automatic logic [DATA_W-1:0] zext(input logic [WIDTH-1:0] v);
    logic [DATA_W-1:0] r;
    r           = {DATA_W{1'b0}};
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_bit #(
      .CNT_W    (CNT_W),
      .DEBOUNCE (DEBOUNCE)
    ) u_db (
      .clk_i    (CLK_I),
      .rst_ni   (RST_I),
      .sw_i     (dipsw[gi]),
      .raw_o    (raw_s[gi]),
      .stable_o (stable_s[gi]),
      .accept_o (accept_s[gi])
    );
  end

  // An access completes on the edge where the strobe is seen with no ack
  // outstanding, which gives a 2-cycle access and alternate acks on a held strobe.
  assign access_s = STB_I & ~ack_q;

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    case (ADR_I)
      ADR_STATE:  rd_data_s = zext(stable_s);
      ADR_CHANGE: rd_data_s = zext(change_q);
      ADR_MASK:   rd_data_s = zext(mask_q);
      ADR_RAW:    rd_data_s = zext(raw_s);
      default:    rd_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Register next-state: writes land on the acking edge; a new accepted
  // edge is OR-ed in after the clear so set wins over a same-cycle clear.
  always_comb begin
    clear_s = {WIDTH{1'b0}};
    mask_d  = mask_q;
    dat_d   = dat_q;
    ack_d   = access_s;
    if (access_s) begin
      dat_d = rd_data_s;
      if (WE_I && (ADR_I == ADR_CHANGE)) begin
        clear_s = DAT_I[WIDTH-1:0];
      end else if (WE_I && (ADR_I == ADR_MASK)) begin
        mask_d = DAT_I[WIDTH-1:0];
      end else begin
        clear_s = {WIDTH{1'b0}};
      end
    end else begin
      dat_d = dat_q;
    end
    change_d = (change_q & ~clear_s) | accept_s;
  end

  // Bus-visible state registers.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      change_q <= {WIDTH{1'b0}};
      mask_q   <= {WIDTH{1'b0}};
      ack_q    <= 1'b0;
      dat_q    <= {DATA_W{1'b0}};
    end else begin
      change_q <= change_d;
      mask_q   <= mask_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  // Decoded only from flops, so it cannot glitch on input activity.
  assign INT_O = |(change_q & mask_q);

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int HSZ = 64;

  logic        CLK_I;
  logic        RST_I;
  logic [7:0]  dipsw;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        INT_O;

  switch_debounce #(.WIDTH(W), .CNT_W(4), .DEBOUNCE(D)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .dipsw (dipsw),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ADR_I (ADR_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .ACK_O (ACK_O),
    .INT_O (INT_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: synchroniser delay line plus a window rule -- a level is
  // accepted when the last D pre-edge synchronised samples, all taken after
  // the most recent reset or acceptance, differ from the accepted level.
  logic [7:0]  m_s1, m_s2, m_stable, m_change, m_mask;
  logic        m_ack;
  logic [31:0] m_dat;
  logic [7:0]  hist [0:HSZ-1];
  int          floor_e [0:W-1];
  int          edge_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    logic [7:0] acc, clr, rd;
    logic       ok, access;
    int         e;
    edge_n++;
    if (!RST_I) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00; m_change = 8'h00;
      m_mask = 8'h00; m_ack = 1'b0; m_dat = 32'h0;
      for (int i = 0; i < W; i++) floor_e[i] = edge_n;
    end else begin
      hist[edge_n % HSZ] = m_s2;
      acc = 8'h00;
      for (int i = 0; i < W; i++) begin
        ok = 1'b1;
        for (int j = 0; j < D; j++) begin
          e = edge_n - j;
          if (e <= floor_e[i]) ok = 1'b0;
          else if (hist[e % HSZ][i] == m_stable[i]) ok = 1'b0;
        end
        acc[i] = ok;
      end
      access = STB_I && !m_ack;
      clr = 8'h00;
      if (access) begin
        case (ADR_I)
          2'd0: rd = m_stable;
          2'd1: rd = m_change;
          2'd2: rd = m_mask;
          default: rd = m_s2;
        endcase
        m_dat = {24'h0, rd};
        if (WE_I && ADR_I == 2'd1) clr = DAT_I[7:0];
        if (WE_I && ADR_I == 2'd2) m_mask = DAT_I[7:0];
      end
      m_change = (m_change & ~clr) | acc;
      m_stable = m_stable ^ acc;
      for (int i = 0; i < W; i++) if (acc[i]) floor_e[i] = edge_n;
      m_s2 = m_s1;
      m_s1 = dipsw;
      m_ack = access;
    end
  endtask

  // One clock: update the model at the edge, compare outputs on the falling edge.
  task automatic tick();
    @(posedge CLK_I);
    model_edge();
    @(negedge CLK_I);
    check_eq("ack", {31'h0, ACK_O}, {31'h0, m_ack});
    check_eq("dat", DAT_O, m_dat);
    check_eq("int", {31'h0, INT_O}, {31'h0, |(m_change & m_mask)});
  endtask

  task automatic access(input logic we, input logic [1:0] adr, input logic [31:0] dat);
    STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    tick();
    STB_I = 1'b0; WE_I = 1'b0;
    tick();
  endtask

  initial begin
    RST_I = 1'b0; dipsw = 8'hFF; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 2'd0; DAT_I = 32'h0;
    for (int i = 0; i < HSZ; i++) hist[i] = 8'h00;
    tick(); tick();
    check_eq("rst_dat", DAT_O, 32'h0);
    check_eq("rst_ack", {31'h0, ACK_O}, 32'h0);
    RST_I = 1'b1;
    // held STATE read across the post-reset debounce window
    STB_I = 1'b1; ADR_I = 2'd0;
    repeat (12) tick();
    STB_I = 1'b0; tick();
    access(1'b0, 2'd1, 32'h0);
    check_eq("rst_change", DAT_O, 32'h000000FF);

    // clean edge on bit0
    dipsw = 8'h00; repeat (8) tick();
    access(1'b1, 2'd2, 32'h1);
    access(1'b1, 2'd1, 32'hFF);
    dipsw = 8'h01;
    repeat (3) access(1'b0, 2'd3, 32'h0);
    access(1'b0, 2'd0, 32'h0);
    check_eq("clean_state", DAT_O, 32'h00000001);

    // bounce on bit1
    access(1'b1, 2'd1, 32'hFF);
    dipsw[1] = 1'b1; tick(); tick();
    dipsw[1] = 1'b0; tick(); tick();
    dipsw[1] = 1'b1; repeat (10) tick();
    access(1'b0, 2'd1, 32'h0);
    check_eq("bounce_change", DAT_O, 32'h00000002);

    // W1C race on bit2: clear write acked on the accepting edge
    access(1'b1, 2'd1, 32'hFF);
    access(1'b1, 2'd2, 32'h04);
    dipsw[2] = 1'b1;
    repeat (5) tick();
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = 2'd1; DAT_I = 32'h04;
    tick();
    STB_I = 1'b0; WE_I = 1'b0;
    tick();
    access(1'b0, 2'd1, 32'h0);
    check_eq("race_set_wins", {31'h0, DAT_O[2]}, 32'h1);
    access(1'b1, 2'd1, 32'h04);
    check_eq("race_int_fall", {31'h0, INT_O}, 32'h0);

    // bus behaviour
    access(1'b1, 2'd2, 32'hA5);
    STB_I = 1'b1; ADR_I = 2'd2;
    repeat (4) tick();
    STB_I = 1'b0; tick();
    check_eq("mask_a5", DAT_O, 32'h000000A5);
    access(1'b1, 2'd2, 32'hFFFFFFFF);
    access(1'b0, 2'd2, 32'h0);
    check_eq("mask_ff", DAT_O, 32'h000000FF);
    access(1'b1, 2'd0, 32'h0);
    access(1'b0, 2'd0, 32'h0);
    check_eq("state_ro", DAT_O, 32'h00000007);

    // reset mid-debounce on bit3
    dipsw[3] = 1'b1;
    repeat (4) tick();
    RST_I = 1'b0; tick();
    RST_I = 1'b1;
    STB_I = 1'b1; ADR_I = 2'd0;
    repeat (14) tick();
    STB_I = 1'b0; tick();

    // randomized traffic and switch activity
    repeat (2000) begin
      if ($urandom_range(0, 5) == 0) dipsw[$urandom_range(0, 7)] ^= 1'b1;
      STB_I = 1'($urandom_range(0, 1));
      WE_I  = 1'($urandom_range(0, 1));
      ADR_I = 2'($urandom_range(0, 3));
      DAT_I = $urandom;
      RST_I = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
